uart_rx: RTL
============

# uart_rx

UART receiver: the receive-side counterpart of the transmit path (PISO, start/stop/parity mux). It deserialises an asynchronous serial line into parallel bytes. The block oversamples the line with a fixed clocks-per-bit count, samples each bit at its centre and checks parity and stop bit. Each frame is reported with a one-cycle valid pulse and error flags.

## Interface
- CLKS_PER_BIT, default 16: system clock cycles per serial bit; even, >= 4
- DATA_BITS, default 8: data bits per frame, LSB first
- clk  input  1  system clock, rising edge
- n_rst  input  1  asynchronous active-low reset
- rx_data_i  input  1  serial line, idle high, asynchronous to clk
- data_o  output  DATA_BITS  last received byte; holds until next frame completes
- valid_o  output  1  one-cycle pulse when a frame completes (with or without error)
- parity_err_o  output  1  parity mismatch on last frame; updated with valid_o
- frame_err_o  output  1  stop bit sampled low on last frame; updated with valid_o
- busy_o  output  1  high in any state other than IDLE

## Operation
- rx_data_i passes through a 2-flop synchroniser (reset value 1), then an edge register (reset value 1).
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - On a falling edge of the synchronised line (prev 1, now 0), clear the bit counter and go to START.
- START:
  - Count CLKS_PER_BIT/2 cycles to reach mid-start.
  - If the line is 1 there, it is a false start: return to IDLE with no valid_o.
  - Otherwise reset the bit timer and go to DATA.
- DATA:
  - Sample every CLKS_PER_BIT cycles and shift into the MSB of the shift register (LSB first on the wire).
  - After DATA_BITS samples, go to PARITY (if compiled in), otherwise STOP.
- PARITY: sample once after CLKS_PER_BIT cycles. Parity is even: the XOR of data and parity bits must be 0.
- STOP:
  - Sample after CLKS_PER_BIT cycles.
  - Next cycle: load data_o, update both error flags, pulse valid_o, return to IDLE.
- IDLE is re-entered at mid-stop, so a start edge arriving half a bit later is caught (back-to-back frames).
- Break or line stuck low: frame_err_o=1, data_o=0. No new frame starts until the line returns high and then falls again.
- Reset mid-frame: all state is cleared immediately and the partial frame is discarded.
- Reset values: data_o=0, valid_o=0, parity_err_o=0, frame_err_o=0, busy_o=0, FSM=IDLE.

## Timing
- t0 is the cycle the edge register detects the falling edge. This is 2–3 cycles after the rx_data_i transition, due to the synchroniser.
- Mid-start sample at t0 + CLKS_PER_BIT/2.
- Data bit i sampled at t0 + CLKS_PER_BIT/2 + (i+1)·CLKS_PER_BIT.
- Stop sampled at t0 + CLKS_PER_BIT/2 + (DATA_BITS+1+P)·CLKS_PER_BIT, where P=1 with parity, else 0.
- valid_o goes high exactly one cycle after the stop sample.
- Defaults, no parity: valid_o at t0+153. With parity: t0+169.
- Bit timer width: $clog2(CLKS_PER_BIT). Bit counter width: $clog2(DATA_BITS+1). Both count up and clear on wrap.
- Simultaneous stop sample and new falling edge cannot occur, since the edge needs a 1 at the stop centre.

## Configuration
- UART_RX_PARITY_EN defined:
  - PARITY state is present; frame is start + DATA_BITS + parity + stop.
  - parity_err_o is computed as above.
- UART_RX_PARITY_EN undefined:
  - PARITY state is absent; DATA goes directly to STOP.
  - parity_err_o is tied to 0.

## Structure
- Package uart_pkg:
  - rx_state_t enum (IDLE, START, DATA, PARITY, STOP);
  - localparams for the default CLKS_PER_BIT and DATA_BITS;
  - a shared even-parity function for the transmitter's parity generator.
- Sub-module sync2: 2-flop synchroniser with parameterised reset value, instantiated for rx_data_i.
- Remaining logic (FSM, bit timer, bit counter, shift register, output registers) lives in uart_rx.

## Test plan
- Reset: hold n_rst=0 with line idle 1 → all outputs 0, busy_o=0.
- Frame 0xA5 (no parity build), good stop → valid_o pulses once at t0+153, data_o=0xA5, both error flags 0.
- Parity build, 0x0F with parity bit 0 → data_o=0x0F, parity_err_o=0. Same byte with parity bit 1 → parity_err_o=1.
- Stop bit driven 0 for 0x3C → valid_o pulses, data_o=0x3C, frame_err_o=1. Line held low afterward → no further valid_o until a rising then falling edge.
- 4-cycle low glitch on the idle line → no valid_o; busy_o returns to 0 at mid-start.
- Back-to-back frames 0x55 then 0xAA with no idle gap → two valid_o pulses with correct data. Assert n_rst mid-frame on a third frame → no valid_o, outputs at reset values.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and defaults.
//   rx_state_t        - receiver FSM state encoding
//   DEF_CLKS_PER_BIT  - default oversampling ratio (clock cycles per bit)
//   DEF_DATA_BITS     - default data bits per frame
//   even_parity()     - even-parity bit for a default-width byte, used by
//                       the transmitter's parity generator
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_DATA_BITS    = 8;

    // Returns the bit that makes the XOR over data and parity equal to 0.
    function automatic logic even_parity(input logic [DEF_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_sync2.sv
// sync2: two-flop synchroniser for a single asynchronous input.
//   RST_VAL  - value both flops take during reset
//   clk      - system clock
//   n_rst    - asynchronous active-low reset
//   d_i      - asynchronous input
//   q_o      - synchronised output, two cycles of latency
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] ff_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) ff_q <= {2{RST_VAL}};
        else        ff_q <= {ff_q[0], d_i};
    end

    assign q_o = ff_q[1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver. Oversamples the serial line at CLKS_PER_BIT clocks
// per bit, samples each bit at its centre, and reports each frame with a
// one-cycle valid pulse plus parity and framing error flags.
//   Optional feature: define UART_RX_PARITY_EN to receive an even-parity bit
//   between the data bits and the stop bit; otherwise parity_err_o is 0.
// Ports:
//   clk           - system clock, rising edge
//   n_rst         - asynchronous active-low reset
//   rx_data_i     - serial line, idle high, asynchronous to clk
//   data_o        - last received data word, held until the next frame ends
//   valid_o       - one-cycle pulse when a frame completes
//   parity_err_o  - parity mismatch on last frame
//   frame_err_o   - stop bit sampled low on last frame
//   busy_o        - receiver is inside a frame (FSM not IDLE)
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 rx_data_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 busy_o
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] HALF_END = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

    logic                 rx_sync;
    logic                 prev_q;
    rx_state_t            state_q;
    logic [TW-1:0]        tmr_q;
    logic [CW-1:0]        cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 perr_q;
    logic                 ferr_q;
`ifdef UART_RX_PARITY_EN
    logic                 par_q;
`endif

    sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .n_rst (n_rst),
        .d_i   (rx_data_i),
        .q_o   (rx_sync)
    );

    logic fall, tick_half, tick_bit;
    assign fall      = prev_q & ~rx_sync;
    assign tick_half = (tmr_q == HALF_END);
    assign tick_bit  = (tmr_q == BIT_END);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            prev_q  <= 1'b1;
            state_q <= IDLE;
            tmr_q   <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            prev_q  <= rx_sync;
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tmr_q <= '0;
                    // A line that stays low after a break never produces
                    // another edge, so no frame restarts until it rises.
                    if (fall) begin
                        cnt_q   <= '0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (tick_half) begin
                        tmr_q   <= '0;
                        state_q <= rx_sync ? IDLE : DATA;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_bit) begin
                        tmr_q   <= '0;
                        // LSB arrives first, so shifting in at the MSB
                        // leaves bit 0 in position 0 after the last sample.
                        shift_q <= {rx_sync, shift_q[DATA_BITS-1:1]};
                        if (cnt_q == LAST_BIT) begin
                            cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick_bit) begin
                        tmr_q   <= '0;
                        par_q   <= rx_sync;
                        state_q <= STOP;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (tick_bit) begin
                        // Leave at mid-stop so a start edge half a bit later
                        // is caught for back-to-back frames.
                        tmr_q   <= '0;
                        state_q <= IDLE;
                        valid_q <= 1'b1;
                        data_q  <= shift_q;
                        ferr_q  <= ~rx_sync;
`ifdef UART_RX_PARITY_EN
                        perr_q  <= ^{shift_q, par_q};
`else
                        perr_q  <= 1'b0;
`endif
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign parity_err_o = perr_q;
    assign frame_err_o  = ferr_q;
    assign busy_o       = (state_q != IDLE);

endmodule
